// File: rtl/kf6845_pkg.sv
// rtl/kf6845_pkg.sv - shared constants and types for the KF6845 stride address generator
// Build option: KF6845_LINE_COMPARE_EN (split-screen line compare; see top level).
package kf6845_pkg;

    // Legal range for the MA_WIDTH parameter.
    localparam int MA_WIDTH_MIN = 9;
    localparam int MA_WIDTH_MAX = 16;

    // Character-row counter width; also the width of line_compare.
    localparam int ROW_COUNT_WIDTH = 8;

    typedef enum logic {
        OFFSET_MODE_CAPTURE = 1'b0,
        OFFSET_MODE_STRIDE  = 1'b1
    } offset_mode_e;

endpackage

// File: rtl/kf6845_stride_regs.sv
// rtl/kf6845_stride_regs.sv - start address, offset and line compare registers with write decode
// Ports:
//   clock, reset (async, active-high)
//   internal_data_bus           register write data
//   write_*_register            write strobes, sampled every clock
//   start_address               MA_WIDTH-bit start address
//   offset                      OFFSET_WIDTH-bit row offset (stride)
//   line_compare                8-bit split-screen row; constant 0 unless KF6845_LINE_COMPARE_EN
module kf6845_stride_regs #(
    parameter int MA_WIDTH     = 14,
    parameter int OFFSET_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              internal_data_bus,
    input  logic                    write_start_address_h_register,
    input  logic                    write_start_address_l_register,
    input  logic                    write_offset_register,
    input  logic                    write_line_compare_register,
    output logic [MA_WIDTH-1:0]     start_address,
    output logic [OFFSET_WIDTH-1:0] offset,
    output logic [7:0]              line_compare
);
    import kf6845_pkg::*;

    // H and L writes are independent so a simultaneous write updates both halves.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_address <= '0;
            offset        <= '0;
        end else begin
            if (write_start_address_h_register)
                start_address[MA_WIDTH-1:8] <= internal_data_bus[MA_WIDTH-9:0];
            if (write_start_address_l_register)
                start_address[7:0] <= internal_data_bus;
            // Size cast truncates a narrow offset and zero-fills a wide one.
            if (write_offset_register)
                offset <= OFFSET_WIDTH'(internal_data_bus);
        end
    end

`ifdef KF6845_LINE_COMPARE_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            line_compare <= '0;
        else if (write_line_compare_register)
            line_compare <= internal_data_bus;
    end
`else
    logic unused_line_compare_write;
    assign unused_line_compare_write = write_line_compare_register;
    assign line_compare = '0;
`endif

endmodule

// File: rtl/kf6845_stride_address_generator.sv
// rtl/kf6845_stride_address_generator.sv - CRTC character memory address (MA) generator with programmable stride
// Build option: KF6845_LINE_COMPARE_EN enables the split-screen line compare reset.
// Ports:
//   clock, reset (async, active-high)
//   video_clock_enable          character clock enable
//   internal_data_bus + write_* register file writes
//   offset_mode                 0 = capture row advance, 1 = programmable stride
//   Horizontal, Horizontal_End, Scanline_End, V_total   timing strobes (already enable-qualified)
//   MA                          current character address
//   row_start                   first character address of the current row
//   start_address               start address register readback
module kf6845_stride_address_generator #(
    parameter int MA_WIDTH     = 14,
    parameter int OFFSET_WIDTH = 8,
    parameter int OFFSET_SHIFT = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                video_clock_enable,
    input  logic [7:0]          internal_data_bus,
    input  logic                write_start_address_h_register,
    input  logic                write_start_address_l_register,
    input  logic                write_offset_register,
    input  logic                write_line_compare_register,
    input  logic                offset_mode,
    input  logic                Horizontal,
    input  logic                Horizontal_End,
    input  logic                Scanline_End,
    input  logic                V_total,
    output logic [MA_WIDTH-1:0] MA,
    output logic [MA_WIDTH-1:0] row_start,
    output logic [MA_WIDTH-1:0] start_address
);
    import kf6845_pkg::*;

    if (MA_WIDTH < MA_WIDTH_MIN || MA_WIDTH > MA_WIDTH_MAX) begin : g_bad_ma_width
        $error("MA_WIDTH must be within 9..16");
    end

    localparam int STRIDE_WIDTH = MA_WIDTH + OFFSET_WIDTH + OFFSET_SHIFT;
    localparam logic [ROW_COUNT_WIDTH:0] ROW_ONE = 1;

    logic [OFFSET_WIDTH-1:0]    offset;
    logic [7:0]                 line_compare;
    logic [MA_WIDTH-1:0]        capture;
    logic [MA_WIDTH-1:0]        stride;
    logic [MA_WIDTH-1:0]        next_row;
    logic [MA_WIDTH-1:0]        advance_row;
    logic [ROW_COUNT_WIDTH-1:0] row_count;

    kf6845_stride_regs #(
        .MA_WIDTH     (MA_WIDTH),
        .OFFSET_WIDTH (OFFSET_WIDTH)
    ) u_regs (
        .clock                          (clock),
        .reset                          (reset),
        .internal_data_bus              (internal_data_bus),
        .write_start_address_h_register (write_start_address_h_register),
        .write_start_address_l_register (write_start_address_l_register),
        .write_offset_register          (write_offset_register),
        .write_line_compare_register    (write_line_compare_register),
        .start_address                  (start_address),
        .offset                         (offset),
        .line_compare                   (line_compare)
    );

    // Shift in a wide intermediate, then keep the low MA_WIDTH bits: the row
    // advance is defined modulo 2^MA_WIDTH.
    assign stride = MA_WIDTH'(STRIDE_WIDTH'(offset) << OFFSET_SHIFT);

    always_comb begin
        next_row = capture;
        if (offset_mode_e'(offset_mode) == OFFSET_MODE_STRIDE)
            next_row = row_start + stride;
        advance_row = next_row;
`ifdef KF6845_LINE_COMPARE_EN
        // Compare against the post-increment row number; widened so a saturated
        // counter never aliases to 0.
        if (line_compare != 8'd0 &&
            {1'b0, line_compare} == ({1'b0, row_count} + ROW_ONE))
            advance_row = '0;
`endif
    end

`ifndef KF6845_LINE_COMPARE_EN
    logic unused_row_compare;
    assign unused_row_compare = ^{line_compare, row_count};
`endif

    // Capture always samples the pre-update MA, and the row advance reads the
    // pre-update capture, so same-cycle Horizontal_End and Scanline_End compose.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            MA        <= '0;
            row_start <= '0;
            capture   <= '0;
            row_count <= '0;
        end else begin
            if (Horizontal_End)
                capture <= MA;

            if (V_total) begin
                row_start <= start_address;
                MA        <= start_address;
                row_count <= '0;
            end else if (Scanline_End) begin
                row_start <= advance_row;
                MA        <= advance_row;
                if (row_count != '1)
                    row_count <= row_count + 1'b1;
            end else if (Horizontal) begin
                MA <= row_start;
            end else if (video_clock_enable) begin
                MA <= MA + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_kf6845_stride_address_generator.sv
// tb/tb_kf6845_stride_address_generator.sv - self-checking bench for kf6845_stride_address_generator
module tb_kf6845_stride_address_generator;

    localparam int MAW  = 14;
    localparam int OFFW = 8;
    localparam int SH   = 1;
    localparam int MOD  = 1 << MAW;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic [7:0] data = 8'h00;
    logic wr_h = 1'b0, wr_l = 1'b0, wr_off = 1'b0, wr_lc = 1'b0;
    logic offset_mode = 1'b0;
    logic h_end = 1'b0, h = 1'b0, se = 1'b0, vt = 1'b0;
    logic [MAW-1:0] ma, row_start, start_address;

    always #5 clock = ~clock;

    kf6845_stride_address_generator #(
        .MA_WIDTH     (MAW),
        .OFFSET_WIDTH (OFFW),
        .OFFSET_SHIFT (SH)
    ) dut (
        .clock                          (clock),
        .reset                          (reset),
        .video_clock_enable             (en),
        .internal_data_bus              (data),
        .write_start_address_h_register (wr_h),
        .write_start_address_l_register (wr_l),
        .write_offset_register          (wr_off),
        .write_line_compare_register    (wr_lc),
        .offset_mode                    (offset_mode),
        .Horizontal                     (h),
        .Horizontal_End                 (h_end),
        .Scanline_End                   (se),
        .V_total                        (vt),
        .MA                             (ma),
        .row_start                      (row_start),
        .start_address                  (start_address)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference state, plain integers.
    int m_ma, m_rs, m_cap, m_cnt, m_start, m_off, m_lc;

    // Raster position: 11 chars/line, 4 lines/row, 6 rows/frame.
    int t_char = 0, t_line = 0, t_row = 0;
    bit t_en = 1'b0;
    bit rand_writes = 1'b0;
    bit l_write_on_vt = 1'b0;
    logic [7:0] vt_data = 8'h00;

    int rs_log[$];
    int ma_log[$];
    int vt_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ma = 0; m_rs = 0; m_cap = 0; m_cnt = 0; m_start = 0; m_off = 0; m_lc = 0;
    endtask

    task automatic model_apply();
        int nr, n_ma, n_rs, n_cnt;
        if (offset_mode)
            nr = (m_rs + (m_off << SH)) % MOD;
        else
            nr = m_cap;
`ifdef KF6845_LINE_COMPARE_EN
        if (m_lc != 0 && m_cnt + 1 == m_lc)
            nr = 0;
`endif
        n_ma = m_ma; n_rs = m_rs; n_cnt = m_cnt;
        if (vt) begin
            n_rs = m_start; n_ma = m_start; n_cnt = 0;
        end else if (se) begin
            n_rs = nr; n_ma = nr; n_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        end else if (h) begin
            n_ma = m_rs;
        end else if (en) begin
            n_ma = (m_ma + 1) % MOD;
        end
        if (h_end) m_cap = m_ma;
        if (wr_h)   m_start = (m_start & 'hFF) | ((int'(data) & ((1 << (MAW - 8)) - 1)) << 8);
        if (wr_l)   m_start = (m_start & ~'hFF) | int'(data);
        if (wr_off) m_off = int'(data) & ((1 << OFFW) - 1);
        if (wr_lc)  m_lc = int'(data);
        m_ma = n_ma; m_rs = n_rs; m_cnt = n_cnt;
    endtask

    // One clock: model follows the edge, then every output is compared on the falling edge.
    task automatic tick();
        @(posedge clock);
        if (reset) model_reset();
        else model_apply();
        @(negedge clock);
        check("MA", 32'(ma), 32'(m_ma));
        check("row_start", 32'(row_start), 32'(m_rs));
        check("start_address", 32'(start_address), 32'(m_start));
        if (vt) begin
            ma_log.delete();
            vt_log.push_back(int'(row_start));
        end
        if (vt || se) rs_log.push_back(int'(row_start));
        if (vt || en) ma_log.push_back(int'(ma));
    endtask

    task automatic clear_strobes();
        en = 1'b0; h_end = 1'b0; h = 1'b0; se = 1'b0; vt = 1'b0;
        wr_h = 1'b0; wr_l = 1'b0; wr_off = 1'b0; wr_lc = 1'b0;
    endtask

    // which: 0=H 1=L 2=offset 3=line_compare
    task automatic reg_write(input int which, input logic [7:0] value);
        clear_strobes();
        data = value;
        case (which)
            0: wr_h = 1'b1;
            1: wr_l = 1'b1;
            2: wr_off = 1'b1;
            default: wr_lc = 1'b1;
        endcase
        tick();
        clear_strobes();
    endtask

    task automatic start_at_frame_end();
        t_row = 5; t_line = 3; t_char = 0; t_en = 1'b0;
        rs_log.delete(); ma_log.delete(); vt_log.delete();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            clear_strobes();
            t_en = !t_en;
            en = t_en;
            if (t_en) begin
                h_end = (t_char == 5);
                h     = (t_char == 10);
                se    = h && (t_line == 3);
                vt    = se && (t_row == 5);
                if (vt && l_write_on_vt) begin
                    wr_l = 1'b1;
                    data = vt_data;
                    l_write_on_vt = 1'b0;
                end
                t_char++;
                if (t_char == 11) begin
                    t_char = 0;
                    t_line++;
                    if (t_line == 4) begin
                        t_line = 0;
                        t_row = (t_row + 1) % 6;
                    end
                end
            end
            if (rand_writes) begin
                int r;
                r = $urandom_range(0, 15);
                data = 8'($urandom);
                case (r)
                    0: wr_h = 1'b1;
                    1: wr_l = 1'b1;
                    2: wr_off = 1'b1;
                    3: wr_lc = 1'b1;
                    4: offset_mode = 1'($urandom);
                    5: begin wr_h = 1'b1; wr_l = 1'b1; end
                    default: ;
                endcase
            end
            tick();
        end
        clear_strobes();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        clear_strobes();
        reset = 1'b1;
        tick();
        tick();
        check("reset_MA", 32'(ma), 32'h0);
        check("reset_row_start", 32'(row_start), 32'h0);
        check("reset_start_address", 32'(start_address), 32'h0);
        reset = 1'b0;

        // Capture mode.
        offset_mode = 1'b0;
        reg_write(0, 8'hAA);
        reg_write(1, 8'h55);
        check("start_hl_readback", 32'(start_address), 32'h2A55);
        start_at_frame_end();
        run_cycles(22 * 13);
        check("capture_row0", 32'(rs_log[0]), 32'h2A55);
        check("capture_row1", 32'(rs_log[1]), 32'h2A5A);
        check("capture_row2", 32'(rs_log[2]), 32'h2A5F);

        // Stride mode.
        offset_mode = 1'b1;
        reg_write(0, 8'h01);
        reg_write(1, 8'h00);
        reg_write(2, 8'h10);
        start_at_frame_end();
        run_cycles(22 * 13);
        check("stride_row0", 32'(rs_log[0]), 32'h0100);
        check("stride_row1", 32'(rs_log[1]), 32'h0120);
        check("stride_row2", 32'(rs_log[2]), 32'h0140);

        // Address wrap and stride wrap.
        reg_write(0, 8'h3F);
        reg_write(1, 8'hFE);
        reg_write(2, 8'hFF);
        start_at_frame_end();
        run_cycles(22 * 6);
        check("wrap_ma0", 32'(ma_log[0]), 32'h3FFE);
        check("wrap_ma1", 32'(ma_log[1]), 32'h3FFF);
        check("wrap_ma2", 32'(ma_log[2]), 32'h0000);
        check("wrap_ma3", 32'(ma_log[3]), 32'h0001);
        check("wrap_stride_row1", 32'(rs_log[1]), 32'h01FC);

        // Start address write in the V_total cycle.
        reg_write(0, 8'h12);
        reg_write(1, 8'h34);
        start_at_frame_end();
        l_write_on_vt = 1'b1;
        vt_data = 8'h00;
        run_cycles(22 * 25);
        check("vt_write_old_reload", 32'(vt_log[0]), 32'h1234);
        check("vt_write_new_frame", 32'(vt_log[1]), 32'h1200);

        // Line compare split screen.
        offset_mode = 1'b1;
        reg_write(0, 8'h02);
        reg_write(1, 8'h00);
        reg_write(2, 8'h08);
        reg_write(3, 8'h02);
        start_at_frame_end();
        run_cycles(22 * 17);
        check("lc_row0", 32'(rs_log[0]), 32'h0200);
        check("lc_row1", 32'(rs_log[1]), 32'h0210);
`ifdef KF6845_LINE_COMPARE_EN
        check("lc_row2", 32'(rs_log[2]), 32'h0000);
        check("lc_row3", 32'(rs_log[3]), 32'h0010);
`else
        check("lc_row2", 32'(rs_log[2]), 32'h0220);
        check("lc_row3", 32'(rs_log[3]), 32'h0230);
`endif

        // Asynchronous reset mid-row.
        run_cycles(31);
        #2 reset = 1'b1;
        #1;
        check("async_reset_MA", 32'(ma), 32'h0);
        check("async_reset_row_start", 32'(row_start), 32'h0);
        check("async_reset_start_address", 32'(start_address), 32'h0);
        model_reset();
        tick();
        tick();
        reset = 1'b0;

        // Randomised register traffic over several frames.
        rand_writes = 1'b1;
        run_cycles(3000);
        rand_writes = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/kf6845_stride_address_generator.md
Name: kf6845_stride_address_generator

Overview:
- Parametrised successor to the KF6845 linear address generator.
- Produces the character memory address MA for a CRTC frame.
- Supports a programmable address width, two row-advance modes and an optional split-screen line-compare reset.
- Sits between the CRTC register file (internal_data_bus plus write strobes) and the horizontal/vertical timing counters, and drives the MA pins.

Parameters:
- MA_WIDTH, 14, address width; legal range 9..16.
- OFFSET_WIDTH, 8, width of the row offset (stride) register.
- OFFSET_SHIFT, 1, left shift applied to the offset, in characters (1 = offset counts words).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- video_clock_enable  in  1  character clock enable.
- internal_data_bus  in  8  register write data.
- write_start_address_h_register  in  1  loads start address bits [MA_WIDTH-1:8] from data[MA_WIDTH-9:0].
- write_start_address_l_register  in  1  loads start address bits [7:0].
- write_offset_register  in  1  loads the offset from data[OFFSET_WIDTH-1:0]; any unused upper offset bits are loaded as 0.
- write_line_compare_register  in  1  loads line_compare[7:0].
- offset_mode  in  1  row-advance mode: 0 = 6845 capture mode, 1 = programmable stride.
- Horizontal  in  1  end-of-scanline strobe, already qualified by the enable.
- Horizontal_End  in  1  end-of-displayed-area strobe, already qualified.
- Scanline_End  in  1  last scanline of a character row; coincides with Horizontal.
- V_total  in  1  end of frame; coincides with Horizontal.
- MA  out  MA_WIDTH  current character address.
- row_start  out  MA_WIDTH  address of the current row's first character.
- start_address  out  MA_WIDTH  start address register readback.

Behaviour:
- Reset: MA, row_start, start_address, offset, capture register, row counter and line_compare are all 0.
- Register writes:
  - Sampled every clock, independent of video_clock_enable.
  - Simultaneous H and L writes are both applied.
  - Writes take effect the following clock.
  - Data bits beyond each register's width are ignored.
- Capture: when Horizontal_End is high, capture <= MA (the pre-increment value).
- next_row:
  - offset_mode 0: capture.
  - offset_mode 1: row_start + (offset << OFFSET_SHIFT).
  - Computed modulo 2^MA_WIDTH.
- Per-clock update priority, highest first:
  1. V_total: row_start <= start_address; MA <= start_address; row counter <= 0.
  2. Scanline_End: row_start <= next_row; MA <= next_row; row counter <= counter+1, saturating at 255.
  3. Horizontal: MA <= row_start.
  4. video_clock_enable: MA <= MA+1, wrapping 2^MA_WIDTH-1 -> 0.
  5. Otherwise: hold.
- Horizontal_End in the same cycle as Horizontal or Scanline_End: the capture uses the old MA, and the row advance uses the old capture.
- Start address write in the same cycle as V_total: the reload uses the old value; the new value applies at the next frame.
- All outputs are registered; latency from a strobe to MA is 1 clock.
- Reset asserted mid-frame clears everything immediately. After release, MA counts from 0 until the first V_total.
- offset_mode is sampled only at Scanline_End; changes mid-row cause no glitch.

Optional Feature:
- Macro: KF6845_LINE_COMPARE_EN.
- With the macro:
  - At Scanline_End (when V_total is not active), if line_compare != 0 and counter+1 == line_compare, then row_start and MA both <= 0 instead of next_row.
  - The row counter still increments.
  - Gives a split screen: the lower part displays from address 0.
- Without the macro: write_line_compare_register and the line_compare register are ignored and optimised away; the row advance is always next_row.

Decomposition:
- Shared package kf6845_pkg:
  - MA_WIDTH range-check constants.
  - Offset mode enum (OFFSET_MODE_CAPTURE = 0, OFFSET_MODE_STRIDE = 1).
  - Row-counter width constant (8).
- One natural sub-module, kf6845_stride_regs: holds the start address, offset and line_compare registers and their write decode. The address datapath stays in the top level.

Test Plan:
- Common timing: enable toggles every clock; 11 characters per line, with Horizontal_End at character 5 and Horizontal at character 10; 4 lines per row; 6 rows per frame.
- Capture mode: write H=0xAA, L=0x55, offset_mode=0 -> start_address=0x2A55. After V_total, rows start at 0x2A55, 0x2A5A, 0x2A5F; each line repeats its row start.
- Stride mode: offset_mode=1, offset=0x10, start 0x0100 -> rows start at 0x0100, 0x0120, 0x0140. Horizontal_End has no effect on the row starts.
- Wrap: start 0x3FFE, MA_WIDTH=14 -> MA sequence 0x3FFE, 0x3FFF, 0x0000, 0x0001. A stride sum exceeding 0x3FFF wraps modulo 2^14.
- Same-cycle start write: write L=0x00 in the exact V_total cycle -> the reload uses the previous start; the next frame uses the new value.
- Line compare (macro defined): line_compare=2, start 0x0200, offset_mode=1, offset=0x08 -> row 0 at 0x0200, row 1 at 0x0210, row 2 at 0x0000, row 3 at 0x0010. Without the macro, row 2 is at 0x0220.
- Reset: assert reset mid-row -> MA=0, row_start=0 and start_address=0 immediately, asynchronously.
